conv_in_fifo: RTL and testbench
===============================

// Module: conv_in_fifo
// PURPOSE
//   Synchronous input FIFO placed directly upstream of the conv layer. Buffers the
//   incoming activation stream: IN_CHANNEL x 8-bit pixels per word, 16 bits at default.
//   The conv stage pops words with fifo_rd_en and receives them one cycle later on
//   o_data/o_valid. The FIFO reports fill level back upstream as almost-full back-pressure.
// PARAMETERS
//   DATA_WIDTH       16  word width in bits (8*IN_CHANNEL)
//   DEPTH            32  number of entries; power of two, >= 4
//   ALMOST_FULL_GAP  4   almost_full asserts when count >= DEPTH-ALMOST_FULL_GAP (1..DEPTH-1)
// PORTS
//   clk          in   1                 rising-edge clock
//   rst_n        in   1                 asynchronous active-low reset
//   i_data       in   DATA_WIDTH        write data from upstream producer
//   i_valid      in   1                 write request; accepted per rules below
//   fifo_rd_en   in   1                 pop request from conv stage
//   o_data       out  DATA_WIDTH        popped word, registered
//   o_valid      out  1                 one-cycle pulse; o_data valid this cycle
//   fifo_empty   out  1                 count == 0
//   fifo_full    out  1                 count == DEPTH
//   fifo_almost_full out 1              count >= DEPTH-ALMOST_FULL_GAP
//   fifo_count   out  $clog2(DEPTH+1)   current occupancy
// BEHAVIOUR
//   - Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, o_data=0, o_valid=0,
//     fifo_empty=1, fifo_full=0, fifo_almost_full=0. Storage array is not cleared.
//   - Reset mid-operation discards all contents; the first post-reset pop requires a new write.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   - rd_acc = fifo_rd_en & ~fifo_empty.
//   - wr_acc = i_valid & (~fifo_full | rd_acc). A write while full is accepted only
//     if a pop is accepted in the same cycle.
//   - Read latency is 1 cycle: on rd_acc at edge N, o_data <= mem[rd_ptr] and
//     o_valid=1 during cycle N+1. Otherwise o_valid=0 and o_data holds its last value.
//   - No write-to-read bypass. A word written at edge N can be popped at edge N+1 at the
//     earliest. A pop while empty is ignored (o_valid stays 0), even with a simultaneous write.
//   - Simultaneous wr_acc & rd_acc: count unchanged; both pointers advance. When full,
//     the read uses the old entry before the write overwrites that slot.
//   - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//   - Status flags are registered, derived from the next count, and valid the same cycle as count.
//   - A rejected write (full, no pop) is dropped silently unless the macro below is defined.
//   - No state machine beyond the pointer/count datapath; throughput 1 word/cycle each side.
// CONFIGURATION
//   CONV_IN_FIFO_ERR_FLAG_EN defined: adds output ports err_overflow (1) and
//     err_underflow (1). These are sticky flags, cleared only by rst_n:
//       err_overflow  sets on i_valid & fifo_full & ~rd_acc
//       err_underflow sets on fifo_rd_en & fifo_empty
//     Each flag sets one cycle after the offending edge.
//   Not defined: ports and logic are absent. Dropped writes and ignored pops leave no record.
// TESTING
//   1. Reset, write 0x0102,0x0304,0x0506 on 3 cycles, then pop 3 -> o_valid on 3
//      consecutive cycles, data in order, 1-cycle latency, count 3->0, empty=1.
//   2. Fill 32 words (0..31) with no pops -> almost_full set at count 28, full at 32.
//      33rd write dropped; pop all 32 -> values 0..31, word 32 never appears.
//   3. Full FIFO, i_valid and fifo_rd_en both high for 1 cycle with data 0xBEEF ->
//      count stays 32, popped word is the oldest entry, 0xBEEF emerges last after draining.
//   4. Empty FIFO, write 0x00AA and pop in the same cycle -> no o_valid. Next cycle's
//      pop -> o_valid with 0x00AA.
//   5. Write 10 words, assert rst_n low mid-stream for 1 cycle -> all outputs at reset
//      values immediately (async). Later pops return nothing until new writes.
//   6. With CONV_IN_FIFO_ERR_FLAG_EN: pop when empty -> err_underflow=1 and held;
//      write when full -> err_overflow=1; both clear only on rst_n.

Source files
------------

// File: rtl/conv_in_fifo.sv
// Activation input FIFO ahead of the conv layer: 1-cycle registered pop, almost-full back-pressure.
// Define CONV_IN_FIFO_ERR_FLAG_EN to add sticky err_overflow/err_underflow outputs.
module conv_in_fifo #(
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 32,
  parameter int ALMOST_FULL_GAP = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_valid,
  input  logic                         fifo_rd_en,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic                         fifo_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef CONV_IN_FIFO_ERR_FLAG_EN
  ,
  output logic                         err_overflow,
  output logic                         err_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOST_FULL_GAP);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] o_data_q;
  logic                  o_valid_q, empty_q, full_q, afull_q;
  logic                  rd_acc, wr_acc;

  assign rd_acc = fifo_rd_en & ~empty_q;
  assign wr_acc = i_valid & (~full_q | rd_acc);

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)
      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc)
      count_d = count_q - CW'(1);
  end

  // Storage is deliberately left out of reset; the read below sees the pre-write value on a full-slot collision.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        o_data_q <= mem_q[rd_ptr_q];
      end
      o_valid_q <= rd_acc;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == FULL_LVL);
      afull_q   <= (count_d >= AF_LVL);
    end
  end

`ifdef CONV_IN_FIFO_ERR_FLAG_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (i_valid & full_q & ~rd_acc);
      udf_q <= udf_q | (fifo_rd_en & empty_q);
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
`endif

  assign o_data           = o_data_q;
  assign o_valid          = o_valid_q;
  assign fifo_empty       = empty_q;
  assign fifo_full        = full_q;
  assign fifo_almost_full = afull_q;
  assign fifo_count       = count_q;

endmodule

// File: tb/tb_conv_in_fifo.sv
// Directed bench for conv_in_fifo: ordering, latency, full/empty boundaries, async reset.
module tb_conv_in_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        fifo_rd_en = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        fifo_empty, fifo_full, fifo_almost_full;
  logic [5:0]  fifo_count;
`ifdef CONV_IN_FIFO_ERR_FLAG_EN
  logic        err_overflow, err_underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_in_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data           (i_data),
    .i_valid          (i_valid),
    .fifo_rd_en       (fifo_rd_en),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count)
`ifdef CONV_IN_FIFO_ERR_FLAG_EN
    ,
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_valid = 1'b0;
    fifo_rd_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic fill(input int base, input int n);
    i_valid = 1'b1;
    fifo_rd_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_data = 16'(base + k);
      step();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_afull", fifo_almost_full, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;

    // 1: three writes, three pops
    i_valid = 1'b1;
    i_data = 16'h0102; step();
    chk("t1_empty_after_w1", fifo_empty, 0);
    i_data = 16'h0304; step();
    i_data = 16'h0506; step();
    i_valid = 1'b0;
    chk("t1_count3", fifo_count, 3);
    chk("t1_no_valid_w", o_valid, 0);
    fifo_rd_en = 1'b1;
    step();
    chk("t1_v0", o_valid, 1); chk("t1_d0", o_data, 16'h0102); chk("t1_c2", fifo_count, 2);
    step();
    chk("t1_v1", o_valid, 1); chk("t1_d1", o_data, 16'h0304); chk("t1_c1", fifo_count, 1);
    step();
    chk("t1_v2", o_valid, 1); chk("t1_d2", o_data, 16'h0506); chk("t1_c0", fifo_count, 0);
    chk("t1_empty", fifo_empty, 1);
    fifo_rd_en = 1'b0;
    step();
    chk("t1_v_drop", o_valid, 0);
    chk("t1_hold", o_data, 16'h0506);

    // 2: fill 0..31, almost_full at 28, full at 32, 33rd dropped
    i_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      i_data = 16'(k);
      step();
      if (k == 26) chk("t2_af_27", fifo_almost_full, 0);
      if (k == 27) chk("t2_af_28", fifo_almost_full, 1);
      if (k == 30) chk("t2_full_31", fifo_full, 0);
    end
    chk("t2_full", fifo_full, 1);
    chk("t2_count32", fifo_count, 32);
    i_data = 16'd32;
    step();
    i_valid = 1'b0;
    chk("t2_count_drop", fifo_count, 32);
    fifo_rd_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      chk("t2_pop_v", o_valid, 1);
      chk("t2_pop_d", o_data, 32'(k));
      if (k == 0) chk("t2_full_clr", fifo_full, 0);
    end
    step();
    chk("t2_no_w32", o_valid, 0);
    chk("t2_empty", fifo_empty, 1);
    fifo_rd_en = 1'b0;

    // 3: simultaneous write+pop while full
    fill(100, 32);
    chk("t3_full", fifo_full, 1);
    i_valid = 1'b1; fifo_rd_en = 1'b1; i_data = 16'hBEEF;
    step();
    i_valid = 1'b0;
    chk("t3_v", o_valid, 1);
    chk("t3_oldest", o_data, 100);
    chk("t3_count", fifo_count, 32);
    chk("t3_full_kept", fifo_full, 1);
    for (int k = 1; k < 32; k++) begin
      step();
      chk("t3_drain", o_data, 32'(100 + k));
    end
    step();
    chk("t3_last_v", o_valid, 1);
    chk("t3_last_beef", o_data, 16'hBEEF);
    chk("t3_empty", fifo_empty, 1);
    fifo_rd_en = 1'b0;

    // 4: no write-to-read bypass
    i_valid = 1'b1; fifo_rd_en = 1'b1; i_data = 16'h00AA;
    step();
    i_valid = 1'b0;
    chk("t4_no_bypass", o_valid, 0);
    chk("t4_count1", fifo_count, 1);
    step();
    chk("t4_v", o_valid, 1);
    chk("t4_d", o_data, 16'h00AA);
    chk("t4_c0", fifo_count, 0);
    fifo_rd_en = 1'b0;
    step();

    // 5: async reset mid-stream
    fill(16'h0200, 10);
    chk("t5_count10", fifo_count, 10);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    chk("t5_pre_v", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_v", o_valid, 0);
    chk("t5_async_d", o_data, 0);
    chk("t5_async_cnt", fifo_count, 0);
    chk("t5_async_empty", fifo_empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fifo_rd_en = 1'b1;
    step();
    chk("t5_pop_nothing", o_valid, 0);
    chk("t5_still_empty", fifo_empty, 1);
    fifo_rd_en = 1'b0;
    i_valid = 1'b1; i_data = 16'h1234;
    step();
    i_valid = 1'b0; fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    chk("t5_new_v", o_valid, 1);
    chk("t5_new_d", o_data, 16'h1234);

`ifdef CONV_IN_FIFO_ERR_FLAG_EN
    // 6: sticky error flags
    do_reset();
    chk("t6_rst_ovf", err_overflow, 0);
    chk("t6_rst_udf", err_underflow, 0);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    chk("t6_udf_set", err_underflow, 1);
    chk("t6_ovf_clr", err_overflow, 0);
    step();
    chk("t6_udf_held", err_underflow, 1);
    fill(0, 32);
    chk("t6_ovf_not_yet", err_overflow, 0);
    i_valid = 1'b1; i_data = 16'hDEAD;
    step();
    i_valid = 1'b0;
    chk("t6_ovf_set", err_overflow, 1);
    step();
    chk("t6_ovf_held", err_overflow, 1);
    do_reset();
    chk("t6_ovf_rst", err_overflow, 0);
    chk("t6_udf_rst", err_underflow, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
